// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
// Holds the default operand/opcode widths, the ALU opcode encoding and the
// arbiter FSM state type. Imported by alu_arbiter and rr_arb2.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    // ALU opcode encoding; 3'b101..3'b111 make the ALU return 0.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
// Ports:
//   valid0, valid1 : request valids
//   prio           : tie-break pointer, 0 favours requester 0
//   any            : at least one requester is valid
//   gnt            : winning requester index (0 or 1), meaningful when any=1
module rr_arb2
    import alu_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic any,
    output logic gnt
);

    assign any = valid0 | valid1;
    // A lone requester always wins; the pointer only breaks ties.
    assign gnt = (valid0 && valid1) ? prio : valid1;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A command is accepted in IDLE, its operands drive the ALU during EXEC, the
// captured result is offered back to the granted requester in RESP.
// Optional feature macro: ALU_FLAGS_EN adds rsp0_zero/rsp1_zero outputs.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b       : command handshake for requester N
//   rspN_valid/ready/data         : result handshake for requester N
//   alu_op, alu_a, alu_b          : registered operands to the ALU
//   alu_result                    : combinational ALU result
//   rspN_zero (ALU_FLAGS_EN only) : result-was-zero flag, travels with data
//
// state | meaning
// IDLE  | waiting for a command; ready follows the arbiter grant
// EXEC  | ALU sees latched operands; result captured at end of cycle
// RESP  | result held on rsp of granted requester until taken
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result
`ifdef ALU_FLAGS_EN
    ,
    output logic              rsp0_zero,
    output logic              rsp1_zero
`endif
);

    import alu_pkg::*;

    state_t            state;
    logic              prio;
    logic              gnt_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic              arb_any;
    logic              arb_gnt;
    logic              take;
    logic              rsp_done;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .prio   (prio),
        .any    (arb_any),
        .gnt    (arb_gnt)
    );

    // rst masks ready so nothing looks accepted while reset is held.
    assign take       = !rst && (state == IDLE) && arb_any;
    assign req0_ready = take && !arb_gnt;
    assign req1_ready = take && arb_gnt;

    assign rsp_done = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            gnt_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        op_q  <= arb_gnt ? req1_op : req0_op;
                        a_q   <= arb_gnt ? req1_a  : req0_a;
                        b_q   <= arb_gnt ? req1_b  : req0_b;
                        gnt_q <= arb_gnt;
                        prio  <= !arb_gnt;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q        <= alu_result;
                    rsp0_valid_q <= !gnt_q;
                    rsp1_valid_q <= gnt_q;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;

`ifdef ALU_FLAGS_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (state == EXEC) begin
            zero_q <= (alu_result == '0);
        end
    end

    assign rsp0_zero = zero_q;
    assign rsp1_zero = zero_q;
`else
    // No result flags in this build.
`endif

endmodule
